// File: rtl/me_run_ctrl.sv
// Run controller for the motion-estimation core: debounced start/stop buttons,
// single/repeat runs with a 4-phase req/ack handshake, timeout and result capture.

module me_run_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_s1, r_s2, r_lvl, r_press;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // The level flips on the DEB_CYCLES-th consecutive sample that differs from it.
  assign w_flip  = (r_s2 != r_lvl) && (r_cnt == CW'(DEB_CYCLES - 1));
  assign o_press = r_press;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_lvl   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= i_btn_n;
      r_s2    <= r_s1;
      r_press <= w_flip & ~r_s2;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module me_run_ctrl #(
  parameter int SAD_WIDTH  = 16,
  parameter int CNT_WIDTH  = 12,
  parameter int RUNS_WIDTH = 8,
  parameter int CYC_WIDTH  = 24,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_n,
  input  logic                  stop_n,
  input  logic                  mode,
  input  logic [RUNS_WIDTH-1:0] run_count,
  output logic                  req,
  input  logic                  ack,
  input  logic [SAD_WIDTH-1:0]  min_sad,
  input  logic [CNT_WIDTH-1:0]  min_mvec,
  output logic [SAD_WIDTH-1:0]  last_sad,
  output logic [CNT_WIDTH-1:0]  last_mvec,
  output logic [SAD_WIDTH-1:0]  best_sad,
  output logic [CNT_WIDTH-1:0]  best_mvec,
  output logic [CYC_WIDTH-1:0]  last_cycles,
  output logic [RUNS_WIDTH-1:0] runs_done,
  output logic                  busy,
  output logic                  timeout
);
  localparam logic [CYC_WIDTH-1:0] TO_LAST = CYC_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t                r_state, w_nxt;
  logic                  w_start_prs, w_stop_prs;
  logic                  w_begin, w_cap, w_to, w_done;
  logic                  r_mode, r_stop_pend, r_timeout;
  logic [RUNS_WIDTH-1:0] r_run_cnt, r_runs_done;
  logic [CYC_WIDTH-1:0]  r_cyc, r_last_cyc;
  logic [SAD_WIDTH-1:0]  r_last_sad, r_best_sad;
  logic [CNT_WIDTH-1:0]  r_last_mvec, r_best_mvec;

  me_run_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .rst_n(rst_n), .i_btn_n(start_n), .o_press(w_start_prs));
  me_run_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk(clk), .rst_n(rst_n), .i_btn_n(stop_n), .o_press(w_stop_prs));

  // A zero run_count means run until stopped.
  assign w_done = r_stop_pend || w_stop_prs || !r_mode ||
                  ((r_run_cnt != '0) && (r_runs_done == r_run_cnt));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_begin = 1'b0;
    w_cap   = 1'b0;
    w_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_prs && !w_stop_prs) begin
          w_begin = 1'b1;
          w_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        if (ack) begin
          w_cap = 1'b1;
          w_nxt = S_REL;
        end else if (r_cyc == TO_LAST) begin
          w_to  = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      S_REL: begin
        if (!ack) w_nxt = w_done ? S_IDLE : S_REQ;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_run_cnt   <= '0;
      r_stop_pend <= 1'b0;
      r_timeout   <= 1'b0;
      r_runs_done <= '0;
      r_cyc       <= '0;
      r_last_cyc  <= '0;
      r_last_sad  <= '0;
      r_last_mvec <= '0;
      r_best_sad  <= '1;
      r_best_mvec <= '0;
    end else begin
      r_cyc <= (r_state == S_REQ) ? r_cyc + 1'b1 : '0;
      if (w_begin) begin
        r_mode      <= mode;
        r_run_cnt   <= run_count;
        r_runs_done <= '0;
        r_timeout   <= 1'b0;
        r_stop_pend <= 1'b0;
        r_best_sad  <= '1;
        r_best_mvec <= '0;
      end
      if (w_stop_prs && (r_state != S_IDLE)) r_stop_pend <= 1'b1;
      if (w_to) r_timeout <= 1'b1;
      if (w_cap) begin
        r_last_sad  <= min_sad;
        r_last_mvec <= min_mvec;
        r_last_cyc  <= r_cyc;
        if (r_runs_done != '1) r_runs_done <= r_runs_done + 1'b1;
        // Strict compare: on a tie the earlier run's vector is kept.
        if (min_sad < r_best_sad) begin
          r_best_sad  <= min_sad;
          r_best_mvec <= min_mvec;
        end
      end
    end
  end

  assign req         = (r_state == S_REQ);
  assign busy        = (r_state != S_IDLE);
  assign timeout     = r_timeout;
  assign runs_done   = r_runs_done;
  assign last_cycles = r_last_cyc;
  assign last_sad    = r_last_sad;
  assign last_mvec   = r_last_mvec;
  assign best_sad    = r_best_sad;
  assign best_mvec   = r_best_mvec;
endmodule

// File: doc/me_run_ctrl.md
Name: me_run_ctrl

Overview:
- Parametrised run controller for the motion-estimation core on the FPGA board.
- Successor to the single-button req latch: debounced start/stop buttons, single-shot or repeat mode with a programmable run count, and a 4-phase req/ack handshake with timeout.
- Captures the last and best (minimum SAD) results and a per-run cycle count for display.
- Sits between the board buttons and me_top; its outputs feed the 7-segment display.

Parameters:
SAD_WIDTH, 16, width of min_sad and result SAD registers
CNT_WIDTH, 12, width of min_mvec and result vector registers
RUNS_WIDTH, 8, width of run_count and runs_done
CYC_WIDTH, 24, width of the per-run cycle counter
DEB_CYCLES, 4, consecutive stable samples required to change a debounced button level (>=2)
TIMEOUT, 1048576, max cycles req may stay high without ack (<= 2**CYC_WIDTH)

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  synchronous active-low reset
start_n  in  1  start button, active low, asynchronous
stop_n  in  1  stop button, active low, asynchronous
mode  in  1  0 = single run, 1 = repeat
run_count  in  RUNS_WIDTH  repeat count; 0 = unlimited (repeat mode only)
req  out  1  request to me_top
ack  in  1  completion from me_top
min_sad  in  SAD_WIDTH  SAD result from me_top
min_mvec  in  CNT_WIDTH  vector result from me_top
last_sad  out  SAD_WIDTH  SAD of the most recent completed run
last_mvec  out  CNT_WIDTH  vector of the most recent completed run
best_sad  out  SAD_WIDTH  minimum SAD since the last start
best_mvec  out  CNT_WIDTH  vector belonging to best_sad
last_cycles  out  CYC_WIDTH  req-high cycles of the most recent run
runs_done  out  RUNS_WIDTH  completed runs since start, saturating
busy  out  1  high when not IDLE
timeout  out  1  sticky; set on timeout, cleared by the next start

Behaviour:
- Reset: req=0, busy=0, timeout=0, last_*=0, last_cycles=0, runs_done=0, best_sad=all ones, best_mvec=0. Debounced levels=1 (released); synchronisers=1. State IDLE.
- Input conditioning: 2-flop synchroniser per button, then debounce. A counter increments while the synchronised value differs from the debounced level and resets to 0 when they are equal. The debounced level takes the new value after DEB_CYCLES consecutive differing samples.
- A 1→0 transition of the debounced level produces a one-cycle registered press pulse. Glitches shorter than DEB_CYCLES cycles produce no pulse.
- FSM states: IDLE, REQ, RELEASE.
- IDLE:
  - On start press: latch mode and run_count, clear runs_done/timeout/stop_pending, set best_sad to all ones, best_mvec=0, go to REQ.
  - A stop press in the same cycle wins: stay in IDLE, clear nothing.
- REQ:
  - req=1, busy=1. The cycle counter is 0 in the first REQ cycle and increments each cycle.
  - On ack=1: last_sad<=min_sad, last_mvec<=min_mvec, last_cycles<=counter.
  - Same ack cycle: runs_done increments, saturating at all ones.
  - Same ack cycle: if min_sad < best_sad (strict), update best_sad/best_mvec; ties keep the earlier run. Go to RELEASE.
  - If the counter reaches TIMEOUT-1 with ack=0: timeout<=1, req=0, go to IDLE. No results are captured and runs_done is unchanged.
- RELEASE:
  - req=0; wait for ack=0.
  - Then go to IDLE if stop_pending=1, latched mode=0, or (latched run_count≠0 and runs_done==run_count). Otherwise go to REQ.
  - The next req rises one cycle after ack is seen low.
- Stop press in REQ or RELEASE sets stop_pending. The current run always completes, because me_top cannot be aborted.
- Start press while busy is ignored. mode/run_count changes while busy have no effect.
- Saturated runs_done with run_count=0: runs continue and runs_done stays at all ones.
- Reset in any state returns to the reset values within one cycle. req drops on the reset edge.
- Latency: req rises between DEB_CYCLES+2 and DEB_CYCLES+4 cycles after start_n is first sampled low, given start_n is held low.
- Results update in the ack-capture cycle and are visible the next cycle.

Test Plan:
- Single run, mode=0, DEB_CYCLES=4: hold start_n low 20 cycles → req rises in cycles 6–8. ack high 50 cycles later with min_sad=0x0123, min_mvec=0x045 → last_sad=0x0123, last_mvec=0x045, best equal, last_cycles=50, runs_done=1. After ack low → IDLE, busy=0.
- Repeat, mode=1, run_count=3, SADs 0x200, 0x100, 0x100 with vectors 1, 2, 3 → exactly 3 req pulses, runs_done=3, best_sad=0x100, best_mvec=2 (tie keeps earlier), last_mvec=3.
- Glitch: start_n low 3 cycles → no req. Stop pressed during the 2nd run of run_count=0 repeat → that run completes, runs_done=2, IDLE.
- Timeout with TIMEOUT=64: ack never rises → req falls after 64 cycles, timeout=1, runs_done=0. The next start clears timeout.
- Simultaneous start/stop press in IDLE → no req. Reset asserted mid-REQ → req=0 next cycle and all outputs return to reset values.
